// File: rtl/mux_scan_pkg.sv
// Shared constants and types for the 8:1 mux scanner.
package mux_scan_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;
endpackage

// File: rtl/mux_scan_next_ch.sv
// Channel walker: next higher enabled channel after ch, and lowest enabled channel.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_q,
  input  logic [CH_W-1:0]   ch,
  output logic [CH_W-1:0]   next_ch,
  output logic              last,
  output logic [CH_W-1:0]   low_ch,
  output logic              none
);
  // Descending walk so the lowest qualifying index is the one left standing.
  always_comb begin
    next_ch = ch;
    last    = 1'b1;
    low_ch  = '0;
    none    = 1'b1;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch))) begin
        next_ch = CH_W'(i);
        last    = 1'b0;
      end
      if (mask_q[i]) begin
        low_ch = CH_W'(i);
        none   = 1'b0;
      end
    end
  end
endmodule

// File: rtl/mux_81_scanner.sv
// Steps the 8:1 mux selects through enabled channels, samples y after DWELL
// cycles per channel, and publishes the assembled word with a valid pulse.
module mux_81_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic [7:0] mask,
  input  logic       y,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy
);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [NUM_CH-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [NUM_CH-1:0]   merged;

  logic [CH_W-1:0]     cur_next, cur_low, new_next, new_low;
  logic                cur_last, cur_none, new_last, new_none;
  logic                unused_walk;

  // Walker on the latched mask drives stepping; walker on the live mask
  // picks the first channel whenever a mask is (re)latched.
  mux_scan_next_ch u_cur (
    .mask_q (mask_q),
    .ch     (ch_q),
    .next_ch(cur_next),
    .last   (cur_last),
    .low_ch (cur_low),
    .none   (cur_none)
  );

  mux_scan_next_ch u_new (
    .mask_q (mask),
    .ch     (ch_q),
    .next_ch(new_next),
    .last   (new_last),
    .low_ch (new_low),
    .none   (new_none)
  );

  assign unused_walk = ^{cur_low, cur_none, new_next, new_last};

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    merged   = shadow_q;
    merged[ch_q] = y;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = mask;
          if (new_none) begin
            data_d  = '0;
            valid_d = 1'b1;
          end else begin
            state_d  = SCAN;
            ch_d     = new_low;
            cnt_d    = '0;
            shadow_d = '0;
          end
        end
      end
      SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d    = '0;
          shadow_d = merged;
          if (!cur_last) begin
            ch_d = cur_next;
          end else begin
            data_d  = merged;
            valid_d = 1'b1;
            if (continuous) mask_d = mask;
            if (continuous && !new_none) begin
              ch_d     = new_low;
              shadow_d = '0;
            end else begin
              state_d = IDLE;
              ch_d    = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign {s2, s1, s0} = ch_q;
  assign data         = data_q;
  assign valid        = valid_q;
  assign busy         = (state_q == SCAN);
endmodule
